uart_loopback_buf: RTL and testbench

- Buffered UART echo path, successor to the direct receiver-to-sender loopback.
- Accepts bytes from the existing receiver (data/valid) and stores them in a parametrised FIFO. An integrated serializer retransmits them back-to-back on UART_TX.
- Absorbs RX bursts, flags overrun when bytes are dropped, and exposes fill level for debug.
- Parametrised in bit period, data width, stop-bit count and buffer depth.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_loopback_buf.sv | 155 +++++++++++++++
 tb/tb_uart_loopback_buf.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART echo path.
// Holds the serializer state encoding, frame-length helper and standard bit periods.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Bit periods for the supported baud settings on the system clock.
    localparam int CLK_PER_BIT_115200 = 2584;
    localparam int CLK_PER_BIT_230400 = 1292;
    localparam int CLK_PER_BIT_460800 = 646;

    function automatic int frame_cycles(input int clk_per_bit,
                                        input int data_bits,
                                        input int stop_bits);
        return (1 + data_bits + stop_bits) * clk_per_bit;
    endfunction

    function automatic int clk_per_bit_for(input int baud);
        case (baud)
            115200:  return CLK_PER_BIT_115200;
            230400:  return CLK_PER_BIT_230400;
            default: return CLK_PER_BIT_460800;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read and occupancy count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; pointers and level alone define
    // which entries are valid, which keeps the array mappable to RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_loopback_buf.sv
// Buffered UART echo: received bytes are queued and re-serialized back-to-back.
// Line outputs are registered so the TX pin never glitches on state decode.
module uart_loopback_buf
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_460800,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int DEPTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_BITS-1:0]       in_data,
    input  logic                       in_valid,
    output logic                       out,
    output logic                       tx_busy,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overrun
);

    localparam int CNT_W = $clog2(STOP_BITS*CLK_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS+1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS*CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    tx_state_t            state;
    tx_state_t            state_next;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     idx_next;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_next;
    logic [DATA_BITS-1:0] rd_data;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic                 out_d;
    logic                 busy_d;
    logic                 drop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // A full FIFO only takes a new byte when the serializer pops that cycle.
    assign drop = in_valid && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            out     <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= idx_next;
            shift   <= shift_next;
            out     <= out_d;
            tx_busy <= busy_d;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        idx_next   = bit_idx;
        shift_next = shift;
        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (pop) begin
                    shift_next = rd_data;
                    state_next = START;
                end
            end
            START: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = shift >> 1;
                    idx_next   = bit_idx + 1'b1;
                    if (bit_idx == IDX_LAST) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == STOP_LAST) begin
                    cnt_next = '0;
                    if (pop) begin
                        shift_next = rd_data;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // The next frame is loaded on the last stop cycle so frames stay contiguous.
    always_comb begin
        pop    = 1'b0;
        out_d  = 1'b1;
        busy_d = 1'b1;
        unique case (state)
            IDLE: begin
                busy_d = 1'b0;
                pop    = !empty;
            end
            START:   out_d = 1'b0;
            DATA:    out_d = shift[0];
            STOP:    pop   = !empty && (cnt == STOP_LAST);
            default: busy_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_uart_loopback_buf.sv
// Directed bench for uart_loopback_buf: exact line timing, bursts, overrun,
// push-at-full-with-pop, mid-frame reset and a 7-bit/2-stop configuration.
module tb_uart_loopback_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data_a = '0;
    logic       in_valid_a = 1'b0;
    logic       out_a;
    logic       tx_busy_a;
    logic [2:0] level_a;
    logic       overrun_a;
    logic [6:0] in_data_b = '0;
    logic       in_valid_b = 1'b0;
    logic       out_b;
    logic       tx_busy_b;
    logic [2:0] level_b;
    logic       overrun_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        int         start;
        bit         ok;
    } frame_t;

    frame_t q_a[$];
    frame_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_loopback_buf #(
        .CLK_PER_BIT (4),
        .DATA_BITS   (8),
        .STOP_BITS   (1),
        .DEPTH       (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data_a),
        .in_valid (in_valid_a),
        .out      (out_a),
        .tx_busy  (tx_busy_a),
        .level    (level_a),
        .overrun  (overrun_a)
    );

    uart_loopback_buf #(
        .CLK_PER_BIT (4),
        .DATA_BITS   (7),
        .STOP_BITS   (2),
        .DEPTH       (4)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data_b),
        .in_valid (in_valid_b),
        .out      (out_b),
        .tx_busy  (tx_busy_b),
        .level    (level_b),
        .overrun  (overrun_b)
    );

    // Line receiver for instance a: 4 cycles/bit, 8 data bits, 1 stop bit.
    logic       ma_act = 1'b0;
    int         ma_ph = 0;
    int         ma_start = 0;
    bit         ma_ok = 1'b1;
    logic [7:0] ma_sh = '0;

    always @(negedge clk) begin
        if (rst) begin
            ma_act <= 1'b0;
        end else if (!ma_act) begin
            if (!out_a) begin
                ma_act   <= 1'b1;
                ma_ph    <= 1;
                ma_start <= cyc;
                ma_ok    <= 1'b1;
            end
        end else begin
            ma_ph <= ma_ph + 1;
            if (ma_ph < 4 && out_a) ma_ok <= 1'b0;
            if (ma_ph >= 36 && !out_a) ma_ok <= 1'b0;
            if (ma_ph % 4 == 2 && ma_ph >= 6 && ma_ph < 36) ma_sh[(ma_ph-6)/4] <= out_a;
            if (ma_ph == 39) begin
                ma_act <= 1'b0;
                q_a.push_back('{data: ma_sh, start: ma_start, ok: ma_ok && out_a});
            end
        end
    end

    // Line receiver for instance b: 4 cycles/bit, 7 data bits, 2 stop bits.
    logic       mb_act = 1'b0;
    int         mb_ph = 0;
    int         mb_start = 0;
    bit         mb_ok = 1'b1;
    logic [6:0] mb_sh = '0;

    always @(negedge clk) begin
        if (rst) begin
            mb_act <= 1'b0;
        end else if (!mb_act) begin
            if (!out_b) begin
                mb_act   <= 1'b1;
                mb_ph    <= 1;
                mb_start <= cyc;
                mb_ok    <= 1'b1;
            end
        end else begin
            mb_ph <= mb_ph + 1;
            if (mb_ph < 4 && out_b) mb_ok <= 1'b0;
            if (mb_ph >= 32 && !out_b) mb_ok <= 1'b0;
            if (mb_ph % 4 == 2 && mb_ph >= 6 && mb_ph < 32) mb_sh[(mb_ph-6)/4] <= out_b;
            if (mb_ph == 39) begin
                mb_act <= 1'b0;
                q_b.push_back('{data: {1'b0, mb_sh}, start: mb_start, ok: mb_ok && out_b});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe_a(input logic [7:0] d);
        in_data_a  = d;
        in_valid_a = 1'b1;
        tick(1);
        in_valid_a = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
    endtask

    task automatic wait_frames_a(input int n, input int budget);
        int k = 0;
        while (q_a.size() < n && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    task automatic wait_frames_b(input int n, input int budget);
        int k = 0;
        while (q_b.size() < n && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    function automatic logic exp_line(input int c, input logic [7:0] d);
        if (c >= 2 && c <= 5) return 1'b0;
        if (c >= 6 && c <= 37) return d[(c-6)/4];
        return 1'b1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 3 cycles with a strobe that must be ignored.
        in_data_a  = 8'hFF;
        in_valid_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_out", out_a, 1);
            check("rst_busy", tx_busy_a, 0);
            check("rst_level", level_a, 0);
            check("rst_overrun", overrun_a, 0);
        end
        in_valid_a = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("idle_out", out_a, 1);
        end
        check("idle_level", level_a, 0);
        check("idle_no_frame", q_a.size(), 0);

        // Single byte 0x55: exact cycle-by-cycle line and busy timing.
        q_a.delete();
        strobe_a(8'h55);
        check("single_level_n", level_a, 1);
        for (int c = 0; c < 46; c++) begin
            check($sformatf("single_out_c%0d", c), out_a, exp_line(c, 8'h55));
            check($sformatf("single_busy_c%0d", c), tx_busy_a, (c >= 2 && c <= 41) ? 1 : 0);
            if (c == 1) check("single_level_pop", level_a, 0);
            tick(1);
        end
        wait_frames_a(1, 20);
        check("single_count", q_a.size(), 1);
        if (q_a.size() > 0) begin
            check("single_data", q_a[0].data, 8'h55);
            check("single_framing", q_a[0].ok, 1);
        end

        // Burst of six: first popped at once, four fill the FIFO, sixth dropped.
        q_a.delete();
        for (int i = 0; i < 6; i++) begin
            in_data_a  = 8'(i + 1);
            in_valid_a = 1'b1;
            tick(1);
            if (i == 4) begin
                check("burst_level_full", level_a, 4);
                check("burst_no_overrun_yet", overrun_a, 0);
            end
        end
        in_valid_a = 1'b0;
        check("burst_level_after_drop", level_a, 4);
        tick(1);
        check("burst_overrun", overrun_a, 1);
        wait_frames_a(5, 260);
        tick(10);
        check("burst_count", q_a.size(), 5);
        for (int i = 0; i < q_a.size(); i++) begin
            check($sformatf("burst_data%0d", i), q_a[i].data, 32'(i + 1));
            check($sformatf("burst_framing%0d", i), q_a[i].ok, 1);
            if (i > 0) check($sformatf("burst_gap%0d", i), q_a[i].start - q_a[i-1].start, 40);
        end
        check("burst_overrun_sticky", overrun_a, 1);
        check("burst_level_drained", level_a, 0);
        check("burst_idle_busy", tx_busy_a, 0);

        // Push while full on the last stop cycle, coinciding with a pop.
        do_reset();
        q_a.delete();
        check("full_pop_overrun_cleared", overrun_a, 0);
        for (int i = 0; i < 5; i++) begin
            strobe_a(8'(i + 1));
        end
        check("full_pop_level_full", level_a, 4);
        tick(36);
        check("full_pop_level_before", level_a, 4);
        strobe_a(8'hA5);
        check("full_pop_level_after", level_a, 4);
        check("full_pop_overrun", overrun_a, 0);
        wait_frames_a(6, 260);
        check("full_pop_count", q_a.size(), 6);
        if (q_a.size() == 6) begin
            check("full_pop_first", q_a[0].data, 8'h01);
            check("full_pop_last", q_a[5].data, 8'hA5);
            check("full_pop_last_framing", q_a[5].ok, 1);
        end
        check("full_pop_overrun_end", overrun_a, 0);

        // Reset pulse mid-frame abandons the frame and empties the buffer.
        do_reset();
        q_a.delete();
        strobe_a(8'h3C);
        tick(20);
        check("midrst_busy_before", tx_busy_a, 1);
        check("midrst_out_before", out_a, exp_line(20, 8'h3C));
        #2 rst = 1'b1;
        #1;
        check("midrst_out", out_a, 1);
        check("midrst_busy", tx_busy_a, 0);
        check("midrst_level", level_a, 0);
        tick(2);
        rst = 1'b0;
        tick(60);
        check("midrst_no_frame", q_a.size(), 0);
        check("midrst_out_idle", out_a, 1);
        check("midrst_busy_idle", tx_busy_a, 0);
        strobe_a(8'h3C);
        wait_frames_a(1, 60);
        check("midrst_resend_count", q_a.size(), 1);
        if (q_a.size() > 0) begin
            check("midrst_resend_data", q_a[0].data, 8'h3C);
            check("midrst_resend_framing", q_a[0].ok, 1);
        end

        // 7 data bits, 2 stop bits: 40-cycle frames, back-to-back.
        q_b.delete();
        in_data_b  = 7'h7F;
        in_valid_b = 1'b1;
        tick(1);
        in_data_b = 7'h00;
        tick(1);
        in_valid_b = 1'b0;
        check("b_level_swap", level_b, 1);
        wait_frames_b(2, 120);
        check("b_count", q_b.size(), 2);
        if (q_b.size() == 2) begin
            check("b_data0", q_b[0].data, 8'h7F);
            check("b_data1", q_b[1].data, 8'h00);
            check("b_framing0", q_b[0].ok, 1);
            check("b_framing1", q_b[1].ok, 1);
            check("b_gap", q_b[1].start - q_b[0].start, 40);
        end
        tick(5);
        check("b_idle_out", out_b, 1);
        check("b_idle_busy", tx_busy_b, 0);
        check("b_overrun", overrun_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
